// File: rtl/pad_input_monitor.sv
// pad_input_monitor: synchronise, debounce and edge-detect pad inputs into sticky events with one irq
module pad_input_monitor #(
  parameter int NUM_PAD    = 32,
  parameter int DEBOUNCE_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NUM_PAD-1:0]    pad_in_i,
  input  logic [DEBOUNCE_W-1:0] debounce_cycles_i,
  input  logic [NUM_PAD-1:0]    rise_en_i,
  input  logic [NUM_PAD-1:0]    fall_en_i,
  input  logic [NUM_PAD-1:0]    event_clear_i,
  output logic [NUM_PAD-1:0]    pad_level_o,
  output logic [NUM_PAD-1:0]    pad_event_o,
  output logic                  irq_o
);
  logic [NUM_PAD-1:0] meta, sync_q, level_q, event_q, upd, set;
  logic [DEBOUNCE_W-1:0] cnt [NUM_PAD];
  logic [DEBOUNCE_W-1:0] cnt_d [NUM_PAD];
  logic irq_q;
  always_comb begin
    upd = '0;
    set = '0;
    for (int i = 0; i < NUM_PAD; i++) begin
      upd[i] = (sync_q[i] != level_q[i]) && (cnt[i] >= debounce_cycles_i);
      cnt_d[i] = (sync_q[i] == level_q[i] || upd[i]) ? '0 : (&cnt[i] ? cnt[i] : cnt[i] + 1'b1);
      set[i] = upd[i] && (sync_q[i] ? rise_en_i[i] : fall_en_i[i]);
    end
  end
  // an update always flips the level, so XOR with the update mask is the new level
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta    <= '0;
      sync_q  <= '0;
      level_q <= '0;
      event_q <= '0;
      irq_q   <= 1'b0;
      cnt     <= '{default: '0};
    end else begin
      meta    <= pad_in_i;
      sync_q  <= meta;
      level_q <= level_q ^ upd;
      event_q <= set | (event_q & ~event_clear_i);
      irq_q   <= |event_q;
      cnt     <= cnt_d;
    end
  end
  assign pad_level_o = level_q;
  assign pad_event_o = event_q;
  assign irq_o       = irq_q;
endmodule

// File: doc/pad_input_monitor.md
Name: pad_input_monitor

Overview:
- Return path for the pad ring: samples raw pad input levels, synchronises and debounces them, and detects rising/falling edges.
- Latches enabled edges into sticky per-pad event flags, with a single interrupt request.
- Sits beside the pad configuration block in the always-on domain. The system register file drives the enables, debounce setting and clear pulses, and reads back the levels and events.

Parameters:
- NUM_PAD, 32, number of monitored pad inputs
- DEBOUNCE_W, 8, width of the per-pad debounce counter and of the debounce setting

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  asynchronous active-low reset
- pad_in_i  input  NUM_PAD  raw pad input levels, asynchronous to clk_i
- debounce_cycles_i  input  DEBOUNCE_W  debounce length N, shared by all pads
- rise_en_i  input  NUM_PAD  per-pad rising-edge event enable
- fall_en_i  input  NUM_PAD  per-pad falling-edge event enable
- event_clear_i  input  NUM_PAD  per-pad single-cycle clear pulse (write-1-to-clear strobe)
- pad_level_o  output  NUM_PAD  debounced pad level
- pad_event_o  output  NUM_PAD  sticky edge-event flags
- irq_o  output  1  registered OR of all pad_event_o bits

Behaviour:
- Interface: one clock domain, clk_i; rst_ni is asynchronous and active-low.
- Reset:
  - All synchroniser flops, counters, pad_level_o, pad_event_o and irq_o go to 0.
  - Assertion mid-debounce discards all progress.
- Synchroniser:
  - Two flops per pad: sync_q is the second stage.
  - A pad_in_i change set up before edge k appears in sync_q after edge k+1.
- Debounce, per pad, two states:
  - STABLE: sync_q == level_q. Counter is held at 0.
  - PENDING: sync_q != level_q. On each edge the counter increments. When the counter is >= debounce_cycles_i, level_q <= sync_q, the counter goes to 0 and the pad returns to STABLE.
  - If sync_q returns to level_q before the update, the counter clears to 0 and the pad returns to STABLE.
  - The comparison uses the live debounce_cycles_i value. Lowering it below the current count causes an update on the next edge.
  - The counter saturates at 2^DEBOUNCE_W-1.
- Latency:
  - Input change before edge k updates pad_level_o at edge k+2+N.
  - N=0 gives a pure 2-flop synchroniser plus one register stage.
  - A pulse that stays constant in sync_q for fewer than N+1 edges never changes pad_level_o.
- Edge detection:
  - A rising edge is level_q going 0->1; a falling edge is 1->0.
  - On the same edge as the level update, pad_event_o[i] is set when the matching enable is 1.
  - Enables are sampled on that edge. Disabling an enable never clears an existing event.
- Clear:
  - event_clear_i[i] high on an edge clears pad_event_o[i].
  - A set and a clear on the same edge: set wins and the flag stays 1.
  - Clears of other pads are independent.
- irq_o:
  - Registered from the OR of pad_event_o, so it lags the event by one cycle.
  - Deasserts one cycle after the last event clears.
- No combinational path from any input to any output.

Test Plan:
- Reset, then pad_in_i = all 1, N=0, rise_en_i = all 1 → pad_level_o = all 1 exactly 3 edges after the change; pad_event_o = all 1 on the same edge; irq_o = 1 one edge later.
- N=4, pad 3: 0->1 pulse lasting 4 cycles in sync_q → pad_level_o[3] stays 0, no event. Repeat with a 5-cycle pulse → pad_level_o[3] = 1 at edge k+6.
- Pad 7 at level 1, fall_en_i[7]=1, rise_en_i[7]=0: drive 0 → event[7] set. Drive back to 1 → no new event. Pulse event_clear_i[7] → event[7] = 0 next edge; irq_o = 0 one edge later.
- Pad 2 qualifies an edge on the same edge that event_clear_i[2] is pulsed → pad_event_o[2] remains 1.
- N=200 with pad 5 pending at count 50: drop debounce_cycles_i to 10 → pad_level_o[5] updates on the next edge.
- Assert rst_ni asynchronously while pad 1 is pending and event[0] is set → all outputs 0 immediately. After release, with the input held, the debounce restarts from 0.
